// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the fetch/data SRAM arbiter.
//   rsp_owner_e        : which requester owns the read data returning next cycle
//   STARVE_MAX_DEFAULT : default count of consecutive data grants tolerated
//                        while a fetch request is waiting
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_I    = 2'd1,
        RSP_D    = 2'd2
    } rsp_owner_e;

    localparam int STARVE_MAX_DEFAULT = 4;

endpackage : bus_arbiter_pkg

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Two-master arbiter (instruction fetch, data load/store) in front of a single
// port synchronous SRAM. Grants are combinational; read data returns exactly
// one cycle after the grant and is tagged to its owner by a small FSM.
//
// Parameters
//   STARVE_MAX : consecutive data grants allowed while a fetch is pending
//   AW         : address width
//   DW         : data width (byte strobes are DW/8 wide)
//
// Ports
//   clk, arst                      : clock, asynchronous active-high reset
//   i_req_i, i_addr_i              : fetch request / address
//   i_gnt_o, i_rvalid_o            : fetch accepted / fetch read data valid
//   d_req_i, d_we_i, d_addr_i,
//   d_wdata_i, d_wmask_i           : data request / write / address / store data
//   d_gnt_o, d_rvalid_o            : data accepted (write completion) / read valid
//   rdata_o                        : shared read data (pass-through of m_rdata_i)
//   m_req_o, m_we_o, m_addr_o,
//   m_wdata_o, m_wmask_o, m_rdata_i: SRAM port
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic            clk,
    input  logic            arst,

    input  logic            i_req_i,
    input  logic [AW-1:0]   i_addr_i,
    output logic            i_gnt_o,
    output logic            i_rvalid_o,

    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [AW-1:0]   d_addr_i,
    input  logic [DW-1:0]   d_wdata_i,
    input  logic [DW/8-1:0] d_wmask_i,
    output logic            d_gnt_o,
    output logic            d_rvalid_o,

    output logic [DW-1:0]   rdata_o,

    output logic            m_req_o,
    output logic            m_we_o,
    output logic [AW-1:0]   m_addr_o,
    output logic [DW-1:0]   m_wdata_o,
    output logic [DW/8-1:0] m_wmask_o,
    input  logic [DW-1:0]   m_rdata_i
);

    // Counter must be able to hold STARVE_MAX itself; keep at least one bit.
    localparam int            CW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [CW-1:0] r_starve_cnt;
    rsp_owner_e    r_state;
    rsp_owner_e    w_state_nxt;

    logic          w_fetch_prio;
    logic          w_i_gnt;
    logic          w_d_gnt;

    // -------------------------------------------------------------------------
    // Grant: data normally wins; a fetch that has waited through STARVE_MAX
    // data grants takes the port. Exactly one grant whenever anyone requests.
    // -------------------------------------------------------------------------
    assign w_fetch_prio = i_req_i && (r_starve_cnt == STARVE_LIM);
    assign w_d_gnt      = d_req_i && !w_fetch_prio;
    assign w_i_gnt      = i_req_i && !w_d_gnt;

    assign i_gnt_o = w_i_gnt;
    assign d_gnt_o = w_d_gnt;
    assign m_req_o = i_req_i | d_req_i;

    // SRAM request mux; idle drives all fields to zero.
    always_comb begin
        m_we_o    = 1'b0;
        m_addr_o  = '0;
        m_wdata_o = '0;
        m_wmask_o = '0;
        if (w_d_gnt) begin
            m_we_o    = d_we_i;
            m_addr_o  = d_addr_i;
            m_wdata_o = d_wdata_i;
            m_wmask_o = d_wmask_i;
        end else if (w_i_gnt) begin
            m_addr_o  = i_addr_i;
        end
    end

    // -------------------------------------------------------------------------
    // Starvation counter: counts data grants that bypassed a waiting fetch.
    // Any cycle without a fetch request, or a fetch grant, starts over.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_starve_cnt <= '0;
        end else if (!i_req_i || w_i_gnt) begin
            r_starve_cnt <= '0;
        end else if (w_d_gnt && (r_starve_cnt != STARVE_LIM)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Response owner FSM: remembers who owns the SRAM read data arriving next
    // cycle. Writes complete at grant and leave no response behind. A reset
    // clears the tag, so a read granted before reset never reports rvalid.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= RSP_NONE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = RSP_NONE;
        if (w_i_gnt) begin
            w_state_nxt = RSP_I;
        end else if (w_d_gnt && !d_we_i) begin
            w_state_nxt = RSP_D;
        end
    end

    assign i_rvalid_o = (r_state == RSP_I);
    assign d_rvalid_o = (r_state == RSP_D);
    assign rdata_o    = m_rdata_i;

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed scoreboard bench for bus_arbiter. The driver applies one vector per
// cycle, checks the combinational grant/SRAM fields, and queues the expected
// read response (owner, data, cycle). A monitor pops the queue whenever the DUT
// raises an rvalid. A behavioural SRAM supplies read data one cycle later.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          arst;
    logic          i_req_i;
    logic [AW-1:0] i_addr_i;
    logic          i_gnt_o, i_rvalid_o;
    logic          d_req_i, d_we_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic [3:0]    d_wmask_i;
    logic          d_gnt_o, d_rvalid_o;
    logic [DW-1:0] rdata_o;
    logic          m_req_o, m_we_o;
    logic [AW-1:0] m_addr_o;
    logic [DW-1:0] m_wdata_o;
    logic [3:0]    m_wmask_o;
    logic [DW-1:0] m_rdata_i;

    bus_arbiter #(.STARVE_MAX(4), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .arst       (arst),
        .i_req_i    (i_req_i),
        .i_addr_i   (i_addr_i),
        .i_gnt_o    (i_gnt_o),
        .i_rvalid_o (i_rvalid_o),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_wmask_i  (d_wmask_i),
        .d_gnt_o    (d_gnt_o),
        .d_rvalid_o (d_rvalid_o),
        .rdata_o    (rdata_o),
        .m_req_o    (m_req_o),
        .m_we_o     (m_we_o),
        .m_addr_o   (m_addr_o),
        .m_wdata_o  (m_wdata_o),
        .m_wmask_o  (m_wmask_o),
        .m_rdata_i  (m_rdata_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: word i holds {16'hA5A5, byte address}, except 0x80 = 0.
    logic [31:0] mem [256];
    bit          mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] = {16'hA5A5, 16'(i * 4)};
            mem[32]    = 32'h0;
            mem_loaded = 1'b1;
        end
        if (m_req_o) begin
            if (m_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (m_wmask_o[b]) mem[m_addr_o[9:2]][8*b +: 8] = m_wdata_o[8*b +: 8];
            end else begin
                m_rdata_i <= mem[m_addr_o[9:2]];
            end
        end
    end

    typedef struct {
        int          port;   // 1 = fetch, 2 = data
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: every rvalid must match the head of the expected queue.
    always @(negedge clk) begin
        if (!arst) begin
            if (i_rvalid_o || d_rvalid_o) begin
                total++;
                if (i_rvalid_o && d_rvalid_o) begin
                    bad++;
                    $display("FAIL rvalid_both: got i=1 d=1 want one (cycle %0d)", cyc);
                end else if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rvalid_unexpected: got i=%0b d=%0b want none (cycle %0d)",
                             i_rvalid_o, d_rvalid_o, cyc);
                end else begin
                    exp_t e;
                    int   port;
                    e    = q.pop_front();
                    port = i_rvalid_o ? 1 : 2;
                    if (port != e.port || rdata_o !== e.data || cyc != e.due) begin
                        bad++;
                        $display("FAIL rsp: got port=%0d data=%h cyc=%0d want port=%0d data=%h cyc=%0d",
                                 port, rdata_o, cyc, e.port, e.data, e.due);
                    end
                end
            end
            if (q.size() > 0 && q[0].due < cyc) begin
                exp_t e;
                e = q.pop_front();
                total++;
                bad++;
                $display("FAIL rsp_missing: got none want port=%0d data=%h at cyc=%0d",
                         e.port, e.data, e.due);
            end
        end
    end

    // One cycle of stimulus: drive, check combinational outputs mid-cycle,
    // queue expected read response, step to just after the next rising edge.
    task automatic vec(input string nm,
                       input logic ireq, input logic [31:0] iaddr,
                       input logic dreq, input logic dwe, input logic [31:0] daddr,
                       input logic [31:0] dwd, input logic [3:0] dmask,
                       input logic exp_ig, input logic exp_dg,
                       input logic [31:0] exp_rd, input bit keep);
        i_req_i   = ireq;
        i_addr_i  = iaddr;
        d_req_i   = dreq;
        d_we_i    = dwe;
        d_addr_i  = daddr;
        d_wdata_i = dwd;
        d_wmask_i = dmask;
        @(negedge clk);
        chk({nm, "_ignt"}, 32'(i_gnt_o), 32'(exp_ig));
        chk({nm, "_dgnt"}, 32'(d_gnt_o), 32'(exp_dg));
        chk({nm, "_mreq"}, 32'(m_req_o), 32'(ireq | dreq));
        if (exp_dg) begin
            chk({nm, "_maddr"}, m_addr_o, daddr);
            chk({nm, "_mwe"}, 32'(m_we_o), 32'(dwe));
            chk({nm, "_mmask"}, 32'(m_wmask_o), 32'(dmask));
            chk({nm, "_mwdata"}, m_wdata_o, dwd);
        end else if (exp_ig) begin
            chk({nm, "_maddr"}, m_addr_o, iaddr);
            chk({nm, "_mwe"}, 32'(m_we_o), 32'h0);
            chk({nm, "_mmask"}, 32'(m_wmask_o), 32'h0);
        end else begin
            chk({nm, "_maddr"}, m_addr_o, 32'h0);
            chk({nm, "_mwe"}, 32'(m_we_o), 32'h0);
            chk({nm, "_mmask"}, 32'(m_wmask_o), 32'h0);
            chk({nm, "_mwdata"}, m_wdata_o, 32'h0);
        end
        if (keep && exp_ig) q.push_back('{port: 1, data: exp_rd, due: cyc + 1});
        if (keep && exp_dg && !dwe) q.push_back('{port: 2, data: exp_rd, due: cyc + 1});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        arst = 1'b1;
        i_req_i = 1'b1; i_addr_i = 32'h100;
        d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_wmask_i = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state; grant path stays live during reset.
        chk("rst_irv", 32'(i_rvalid_o), 32'h0);
        chk("rst_drv", 32'(d_rvalid_o), 32'h0);
        chk("rst_cnt", 32'(dut.r_starve_cnt), 32'h0);
        chk("rst_ignt", 32'(i_gnt_o), 32'h1);
        chk("rst_maddr", m_addr_o, 32'h100);
        i_req_i = 1'b0;
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;

        // Fetch only.
        vec("f100", 1, 32'h100, 0, 0, 0, 0, 4'h0, 1, 0, 32'hA5A50100, 1);
        // Simultaneous fetch 0x200 and data read 0x40: data first.
        vec("sim1", 1, 32'h200, 1, 0, 32'h40, 0, 4'h0, 0, 1, 32'hA5A50040, 1);
        vec("sim2", 1, 32'h200, 0, 0, 0, 0, 4'h0, 1, 0, 32'hA5A50200, 1);
        // Idle cycle.
        vec("idle", 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h0, 1);

        // Starvation: four data reads pass a waiting fetch, then fetch wins.
        vec("stv1", 1, 32'h300, 1, 0, 32'h10, 0, 4'h0, 0, 1, 32'hA5A50010, 1);
        vec("stv2", 1, 32'h300, 1, 0, 32'h14, 0, 4'h0, 0, 1, 32'hA5A50014, 1);
        vec("stv3", 1, 32'h300, 1, 0, 32'h18, 0, 4'h0, 0, 1, 32'hA5A50018, 1);
        vec("stv4", 1, 32'h300, 1, 0, 32'h1C, 0, 4'h0, 0, 1, 32'hA5A5001C, 1);
        chk("stv_cnt_sat", 32'(dut.r_starve_cnt), 32'h4);
        vec("stv5", 1, 32'h300, 1, 0, 32'h20, 0, 4'h0, 1, 0, 32'hA5A50300, 1);
        chk("stv_cnt_clr", 32'(dut.r_starve_cnt), 32'h0);
        vec("stv6", 0, 0, 1, 0, 32'h20, 0, 4'h0, 0, 1, 32'hA5A50020, 1);

        // Partial write then read back.
        vec("wr80", 0, 0, 1, 1, 32'h80, 32'hDEADBEEF, 4'b0011, 0, 1, 32'h0, 1);
        vec("gap", 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h0, 1);
        vec("rd80", 0, 0, 1, 0, 32'h80, 0, 4'h0, 0, 1, 32'h0000BEEF, 1);

        // Alternating fetch / data reads, back to back.
        vec("alt1", 1, 32'h104, 0, 0, 0, 0, 4'h0, 1, 0, 32'hA5A50104, 1);
        vec("alt2", 0, 0, 1, 0, 32'h44, 0, 4'h0, 0, 1, 32'hA5A50044, 1);
        vec("alt3", 1, 32'h108, 0, 0, 0, 0, 4'h0, 1, 0, 32'hA5A50108, 1);
        vec("alt4", 0, 0, 1, 0, 32'h48, 0, 4'h0, 0, 1, 32'hA5A50048, 1);
        vec("alt5", 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h0, 1);

        // Reset in the cycle after a read grant: response must be dropped.
        vec("rrd", 1, 32'h204, 1, 0, 32'h4C, 0, 4'h0, 0, 1, 32'h0, 0);
        chk("rr_cnt_pre", 32'(dut.r_starve_cnt), 32'h1);
        arst = 1'b1;
        i_req_i = 1'b0;
        d_req_i = 1'b0;
        #1;
        chk("rr_drv", 32'(d_rvalid_o), 32'h0);
        chk("rr_cnt", 32'(dut.r_starve_cnt), 32'h0);
        @(negedge clk);
        #2;
        arst = 1'b0;
        @(posedge clk);
        #1;
        chk("rr_post_drv", 32'(d_rvalid_o), 32'h0);
        chk("rr_post_irv", 32'(i_rvalid_o), 32'h0);
        vec("post", 1, 32'h10C, 0, 0, 0, 0, 4'h0, 1, 0, 32'hA5A5010C, 1);
        vec("tail", 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h0, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bus_arbiter

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, consecutive data grants allowed while fetch waits.
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width (wmask width DW/8).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 arst  in  1  asynchronous, active-high reset.
REQ-006 i_req_i  in  1  fetch request, held with i_addr_i stable until i_gnt_o.
REQ-007 i_addr_i  in  AW  fetch address.
REQ-008 i_gnt_o  out  1  fetch request accepted this cycle.
REQ-009 i_rvalid_o  out  1  fetch read data on rdata_o this cycle.
REQ-010 d_req_i  in  1  data request, held with d_* stable until d_gnt_o.
REQ-011 d_we_i  in  1  data write (1) / read (0).
REQ-012 d_addr_i  in  AW  data address.
REQ-013 d_wdata_i  in  DW  store data.
REQ-014 d_wmask_i  in  DW/8  store byte strobes.
REQ-015 d_gnt_o  out  1  data request accepted this cycle.
REQ-016 d_rvalid_o  out  1  data read data on rdata_o this cycle.
REQ-017 rdata_o  out  DW  shared read data, qualified by i_rvalid_o/d_rvalid_o.
REQ-018 m_req_o  out  1  request to single-port synchronous SRAM.
REQ-019 m_we_o  out  1  SRAM write enable.
REQ-020 m_addr_o  out  AW  SRAM address.
REQ-021 m_wdata_o  out  DW  SRAM write data.
REQ-022 m_wmask_o  out  DW/8  SRAM byte strobes.
REQ-023 m_rdata_i  in  DW  SRAM read data, valid exactly one cycle after a read request.

Function
REQ-024 Grant is combinational, same cycle: m_req_o = i_req_i | d_req_i; at most one of i_gnt_o/d_gnt_o high; exactly one high whenever m_req_o high.
REQ-025 Priority: data wins over fetch, except when starve_cnt == STARVE_MAX and i_req_i high, then fetch wins.
REQ-026 starve_cnt (width clog2(STARVE_MAX+1)): +1 on data grant with i_req_i high and fetch not granted; cleared on fetch grant or when i_req_i low; saturates at STARVE_MAX.
REQ-027 Fetch grant drives m_we_o=0, m_wmask_o=0, m_addr_o=i_addr_i; data grant drives d_* fields; idle drives m_we_o=0, m_wmask_o=0, m_addr_o/m_wdata_o=0.
REQ-028 Response tag FSM states RSP_NONE, RSP_I, RSP_D: next state RSP_I after fetch grant, RSP_D after data read grant, RSP_NONE after write grant or no grant.
REQ-029 i_rvalid_o = (state==RSP_I), d_rvalid_o = (state==RSP_D); read latency exactly 1 cycle grant-to-rvalid.
REQ-030 rdata_o = m_rdata_i combinational pass-through; writes produce no rvalid, d_gnt_o is write completion.
REQ-031 Back-to-back: a new grant in the same cycle a previous response is returned is legal; full throughput one access per cycle.
REQ-032 Requester dropping req before gnt is a protocol violation; the block need not tolerate it.

Reset
REQ-033 While arst high: state=RSP_NONE, starve_cnt=0, all rvalid low; grant logic stays combinational.
REQ-034 Reset asserted mid-read drops the pending response; no rvalid emitted after release for pre-reset grants.

Structure
REQ-035 Shared core package holds rsp_owner_e enum (RSP_NONE, RSP_I, RSP_D) and STARVE_MAX default constant.
REQ-036 Single flat module; no sub-module.

Verification
REQ-037 Fetch only, i_addr_i=0x100 -> i_gnt_o same cycle, m_addr_o=0x100, i_rvalid_o next cycle with rdata_o=mem[0x100].
REQ-038 Simultaneous fetch 0x200 and data read 0x40 -> d_gnt_o first, d_rvalid_o next cycle; i_gnt_o following cycle.
REQ-039 Continuous data reads with fetch pending, STARVE_MAX=4 -> 4 d_gnt_o, then i_gnt_o on 5th cycle, starve_cnt cleared.
REQ-040 Data write 0x80, wdata 0xDEADBEEF, wmask 4'b0011 -> m_we_o=1, m_wmask_o=4'b0011, no d_rvalid_o; later read returns 0x0000BEEF-updated word.
REQ-041 Alternating fetch/data reads each cycle -> rvalid of each tagged to correct port, no bubbles.
REQ-042 arst pulse in cycle after a read grant -> no rvalid after release, starve_cnt=0.
